viper_mem_if: RTL and testbench
===============================

# viper_mem_if

Memory/IO bus interface unit placed directly downstream of the VIPER core. It accepts a single read or write request per transaction from the core, range-checks the 32-bit effective address against the 1M-word space, and drives a simple strobe/acknowledge bus to memory or peripherals. It returns read data or a completion pulse to the core, and raises a sticky error that the core ORs into its STOP flag.

## Interface
- `ADDR_W`, 20: bus address width; legal effective addresses are 0 .. 2^ADDR_W-1.
- `DATA_W`, 32: data word width.
- `TIMEOUT`, 15: maximum number of ISSUE cycles without `mem_ack` before an error; used only with `VIPER_MEM_TIMEOUT_EN`.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `core_req` in 1: request strobe; sampled only in IDLE.
- `core_we` in 1: 1 = write, 0 = read.
- `core_io` in 1: 1 = peripheral space, 0 = memory space.
- `core_addr` in 32: effective address from the core (register + tail).
- `core_wdata` in DATA_W: write data.
- `core_rdata` out DATA_W: read data (MBR); valid while `core_ready` is high and held until the next read completes.
- `core_ready` out 1: one-cycle completion pulse.
- `core_busy` out 1: high whenever state ≠ IDLE.
- `core_err` out 1: sticky error; cleared only by reset.
- `mem_addr` out ADDR_W: registered address (MAR).
- `mem_wdata` out DATA_W: registered write data.
- `mem_rd` out 1: read strobe.
- `mem_wr` out 1: write strobe.
- `mem_io` out 1: space select that accompanies the strobes.
- `mem_rdata` in DATA_W: read data; sampled on the cycle `mem_ack` is high.
- `mem_ack` in 1: transfer acknowledge.

## Operation
- States: IDLE, ISSUE, DONE, ERR.
- IDLE, `core_req` = 1:
  - `core_addr` > 2^ADDR_W-1 → ERR. No strobe is ever driven.
  - Otherwise latch MAR = `core_addr[ADDR_W-1:0]`, the write data, `core_we` and `core_io`, then → ISSUE.
- IDLE, `core_req` = 0: stay in IDLE.
- ISSUE:
  - `mem_rd` = !we and `mem_wr` = we, both decoded from registered state (glitch-free).
  - `mem_addr`, `mem_wdata` and `mem_io` stay stable for the whole of ISSUE.
  - `mem_ack` = 1 → on a read, MBR ← `mem_rdata`; → DONE.
  - `mem_ack` = 0 → stay in ISSUE.
- DONE: `core_ready` = 1 for exactly one cycle, then → IDLE.
- ERR: `core_err` = 1, `core_busy` = 1; terminal until reset. All strobes are low.
- `core_req` in any state other than IDLE is ignored; there is no queueing.
- `mem_ack` outside ISSUE is ignored.
- Write transactions leave MBR unchanged.
- Address check is an unsigned compare on all 32 bits.
  - 0x000F_FFFF is legal.
  - 0x0010_0000 and 0xFFFF_FFFF are illegal.

## Timing
- Reset values: `core_rdata` = 0, `core_ready` = 0, `core_busy` = 0, `core_err` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_rd` = 0, `mem_wr` = 0, `mem_io` = 0; state = IDLE; timeout counter = 0.
- Cycle-level sequence, with the request sampled at edge 0:
  - Strobes are high from edge 0 to edge k, where edge k is the first edge sampling `mem_ack` = 1 (k ≥ 1).
  - `core_ready` is high from edge k to edge k+1.
  - Minimum request-to-ready latency is 2 cycles; back-to-back throughput is 1 transaction per 3 cycles.
- Illegal address: `core_err` rises after edge 0. No strobe appears in any cycle.
- Reset asserted mid-ISSUE: strobes drop asynchronously. No `core_ready` is issued for the aborted transfer.
- `mem_ack` and timeout expiry on the same edge: the ack wins and the transaction completes normally.

## Configuration
- `VIPER_MEM_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to ISSUE and increments each ISSUE cycle without ack.
  - When it reaches TIMEOUT with no ack, the block → ERR and drops the strobes.
- `VIPER_MEM_TIMEOUT_EN` undefined: no counter is built; ISSUE waits indefinitely for `mem_ack`.

## Structure
- Shared package `viper_pkg`:
  - `mem_state_t` enum {IDLE, ISSUE, DONE, ERR}.
  - `VIPER_ADDR_W` = 20, `VIPER_DATA_W` = 32, `VIPER_ADDR_MAX` = 32'h000F_FFFF.
- Natural sub-module: `viper_addr_chk`, a combinational range check with output `legal`, reusable by the core's instruction-fetch path. The FSM, MAR/MBR and timeout counter live in the top module.

## Test plan
- Read, ack after 2 cycles: `core_addr` = 0x0001_2345, `mem_rdata` = 0xDEAD_BEEF.
  - Required: `mem_rd` high for 2 cycles, `mem_addr` = 0x12345.
  - Required: `core_ready` for one cycle with `core_rdata` = 0xDEAD_BEEF.
- Write with immediate ack: `core_addr` = 0x000F_FFFF, `core_wdata` = 0x1234_5678, `core_io` = 1.
  - Required: `mem_wr` = 1 and `mem_io` = 1 for one cycle, `mem_wdata` = 0x1234_5678.
  - Required: `core_ready` 2 cycles after the request; `core_rdata` unchanged.
- Illegal address: `core_addr` = 0x0010_0000.
  - Required: `core_err` = 1 the next cycle, never any strobe.
  - Required: later `core_req` pulses are ignored until reset.
- Timeout, macro defined, TIMEOUT = 15, no ack:
  - Required: → ERR after 15 ISSUE cycles, strobes drop.
  - Required: ack and expiry on the same edge → `core_ready`, no error.
- Reset mid-ISSUE: assert `reset` 1 cycle into a read.
  - Required: strobes low immediately, no `core_ready`.
  - Required: a fresh read after deassertion completes normally.
- `core_req` held high across a whole transaction: exactly one transaction per IDLE visit, with `core_busy` high from the edge after the request until the return to IDLE.

Source files
------------

// File: rtl/viper_pkg.sv
// Shared VIPER definitions: bus widths, address limit and memory-interface states.
package viper_pkg;

    localparam int unsigned VIPER_ADDR_W   = 20;
    localparam int unsigned VIPER_DATA_W   = 32;
    localparam logic [31:0] VIPER_ADDR_MAX = 32'h000F_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } mem_state_t;

endpackage

// File: rtl/viper_addr_chk.sv
// Combinational range check of a 32-bit effective address against a 2^ADDR_W word space.
// Shared by the memory interface and the instruction-fetch path.
module viper_addr_chk
    import viper_pkg::*;
#(
    parameter int unsigned ADDR_W = VIPER_ADDR_W
)(
    input  logic [31:0] addr,
    output logic        legal
);

    localparam logic [31:0] LIMIT = 32'((64'd1 << ADDR_W) - 64'd1);

    // Unsigned compare over the full 32 bits
    assign legal = (addr <= LIMIT);

endmodule

// File: rtl/viper_mem_if.sv
// VIPER memory/IO bus interface: range-checks a core request, drives a strobe/ack
// bus and returns read data or a completion pulse; raises a sticky error.
// Optional feature: define VIPER_MEM_TIMEOUT_EN to abort ISSUE into ERR after TIMEOUT
// cycles without mem_ack.
module viper_mem_if
    import viper_pkg::*;
#(
    parameter int unsigned ADDR_W  = VIPER_ADDR_W,
    parameter int unsigned DATA_W  = VIPER_DATA_W,
    parameter int unsigned TIMEOUT = 15
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic              core_io,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ready,
    output logic              core_busy,
    output logic              core_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_io,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic              w_legal;
    logic              w_latch;
    logic              w_capture;
    logic              w_expire;
    logic              w_we_nxt;
    logic              w_io_nxt;
    logic              r_we;
    logic              r_io;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mbr;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_mem_io;

    viper_addr_chk #(.ADDR_W(ADDR_W)) u_addr_chk (
        .addr  (core_addr),
        .legal (w_legal)
    );

`ifdef VIPER_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Expiry fires on the edge that would bring the count up to TIMEOUT
    assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));

    // ISSUE-cycle counter: cleared on entry, advances on every un-acked ISSUE edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_latch) begin
            r_cnt <= '0;
        end else if ((r_state == ISSUE) && !mem_ack) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused_timeout;

    assign w_expire         = 1'b0;
    assign w_unused_timeout = 1'(TIMEOUT == 0);
`endif

    // Next-state decode; ack has priority over timeout expiry
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (core_req) begin
                    if (w_legal) begin
                        w_state_nxt = ISSUE;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = ERR;
                    end
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    w_state_nxt = DONE;
                    w_capture   = !r_we;
                end else if (w_expire) begin
                    w_state_nxt = ERR;
                end
            end
            DONE:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_we_nxt = w_latch ? core_we : r_we;
    assign w_io_nxt = w_latch ? core_io : r_io;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // MAR/MBR, transaction attributes and registered outputs derived from next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_io     <= 1'b0;
            r_mar    <= '0;
            r_wdata  <= '0;
            r_mbr    <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_mem_io <= 1'b0;
        end else begin
            if (w_latch) begin
                r_we    <= core_we;
                r_io    <= core_io;
                r_mar   <= core_addr[ADDR_W-1:0];
                r_wdata <= core_wdata;
            end
            if (w_capture) begin
                r_mbr <= mem_rdata;
            end
            r_ready  <= (w_state_nxt == DONE);
            r_busy   <= (w_state_nxt != IDLE);
            r_err    <= (w_state_nxt == ERR);
            r_mem_rd <= (w_state_nxt == ISSUE) && !w_we_nxt;
            r_mem_wr <= (w_state_nxt == ISSUE) && w_we_nxt;
            r_mem_io <= (w_state_nxt == ISSUE) && w_io_nxt;
        end
    end

    assign core_rdata = r_mbr;
    assign core_ready = r_ready;
    assign core_busy  = r_busy;
    assign core_err   = r_err;
    assign mem_addr   = r_mar;
    assign mem_wdata  = r_wdata;
    assign mem_rd     = r_mem_rd;
    assign mem_wr     = r_mem_wr;
    assign mem_io     = r_mem_io;

endmodule

// File: tb/tb_viper_mem_if.sv
// Self-checking bench for viper_mem_if: directed cases plus randomized transactions
// compared against a transaction-level model (legality, strobe window, MBR contents).
module tb_viper_mem_if;

    localparam int unsigned TO = 15;

    logic        clock;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic        core_io;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic        core_busy;
    logic        core_err;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_io;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int          checks;
    int          errors;
    logic [31:0] exp_mbr;

    viper_mem_if #(.ADDR_W(20), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_io    (core_io),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ready (core_ready),
        .core_busy  (core_busy),
        .core_err   (core_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_io     (mem_io),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit model_legal(input logic [31:0] a);
        return a < 32'd1048576;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rd"}, 64'(mem_rd), 64'd0);
        check({tag, "_wr"}, 64'(mem_wr), 64'd0);
        check({tag, "_io"}, 64'(mem_io), 64'd0);
    endtask

    task automatic check_reset_values();
        check("rst_rdata", 64'(core_rdata), 64'd0);
        check("rst_ready", 64'(core_ready), 64'd0);
        check("rst_busy",  64'(core_busy),  64'd0);
        check("rst_err",   64'(core_err),   64'd0);
        check("rst_maddr", 64'(mem_addr),   64'd0);
        check("rst_mwdat", 64'(mem_wdata),  64'd0);
        check_quiet("rst");
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        core_req = 1'b0;
        mem_ack  = 1'b0;
        #1;
        check_reset_values();
        @(negedge clock);
        reset   = 1'b0;
        exp_mbr = 32'd0;
    endtask

    // One legal transaction acked on edge k after the request edge
    task automatic do_txn(input logic we, input logic io, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int k, input bit hold);
        @(negedge clock);
        core_req   = 1'b1;
        core_we    = we;
        core_io    = io;
        core_addr  = addr;
        core_wdata = wdata;
        mem_ack    = 1'b0;
        @(posedge clock);
        for (int j = 0; j <= k + 1; j++) begin
            @(negedge clock);
            if (j == 0 && !hold) core_req = 1'b0;
            if (j < k) begin
                check("iss_busy",  64'(core_busy),  64'd1);
                check("iss_rd",    64'(mem_rd),     64'(!we));
                check("iss_wr",    64'(mem_wr),     64'(we));
                check("iss_io",    64'(mem_io),     64'(io));
                check("iss_addr",  64'(mem_addr),   64'(addr[19:0]));
                check("iss_ready", 64'(core_ready), 64'd0);
                check("iss_err",   64'(core_err),   64'd0);
                if (we) check("iss_wdata", 64'(mem_wdata), 64'(wdata));
                mem_ack   = (j + 1 == k);
                mem_rdata = (j + 1 == k) ? rdata : $urandom();
            end else if (j == k) begin
                if (!we) exp_mbr = rdata;
                check("done_ready", 64'(core_ready), 64'd1);
                check("done_rdata", 64'(core_rdata), 64'(exp_mbr));
                check("done_busy",  64'(core_busy),  64'd1);
                check("done_err",   64'(core_err),   64'd0);
                check_quiet("done");
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom();
            end else begin
                check("idle_ready", 64'(core_ready), 64'd0);
                check("idle_busy",  64'(core_busy),  64'd0);
                check("idle_rdata", 64'(core_rdata), 64'(exp_mbr));
                check_quiet("idle");
                core_req = 1'b0;
                mem_ack  = 1'b0;
            end
        end
    endtask

    // Illegal request: immediate sticky error, no strobes, later requests ignored
    task automatic do_illegal(input logic [31:0] addr);
        @(negedge clock);
        core_req  = 1'b1;
        core_we   = 1'($urandom_range(0, 1));
        core_io   = 1'($urandom_range(0, 1));
        core_addr = addr;
        @(posedge clock);
        @(negedge clock);
        core_req = 1'b0;
        check("ill_err",   64'(core_err),   64'd1);
        check("ill_busy",  64'(core_busy),  64'd1);
        check("ill_ready", 64'(core_ready), 64'd0);
        check_quiet("ill");
        for (int j = 0; j < 6; j++) begin
            core_req  = 1'($urandom_range(0, 1));
            core_addr = $urandom_range(0, 32'hFFFFF);
            mem_ack   = 1'($urandom_range(0, 1));
            @(negedge clock);
            check("term_err",   64'(core_err),   64'd1);
            check("term_busy",  64'(core_busy),  64'd1);
            check("term_ready", 64'(core_ready), 64'd0);
            check_quiet("term");
        end
        core_req = 1'b0;
        mem_ack  = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        checks     = 0;
        errors     = 0;
        exp_mbr    = 32'd0;
        reset      = 1'b1;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_io    = 1'b0;
        core_addr  = 32'd0;
        core_wdata = 32'd0;
        mem_rdata  = 32'd0;
        mem_ack    = 1'b0;
        #2;
        check_reset_values();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Directed: read acked after 2 cycles, boundary write with immediate ack
        do_txn(1'b0, 1'b0, 32'h0001_2345, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
        do_txn(1'b1, 1'b1, 32'h000F_FFFF, 32'h1234_5678, 32'hCAFE_F00D, 1, 1'b0);

        // Request held high through a whole transaction
        do_txn(1'b0, 1'b1, 32'h0000_0ABC, 32'h0, 32'h5A5A_A5A5, 3, 1'b1);
        @(negedge clock);
        check("hold_one_txn", 64'(core_busy), 64'd0);

        // Randomized traffic; the model decides legality
        for (int n = 0; n < 30; n++) begin
            a = ($urandom_range(0, 5) == 0) ? $urandom() : $urandom_range(0, 32'hFFFFF);
            if (model_legal(a)) begin
                do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                       $urandom(), $urandom(), int'($urandom_range(1, 4)), 1'b0);
            end else begin
                do_illegal(a);
                do_reset();
            end
        end

`ifdef VIPER_MEM_TIMEOUT_EN
        // Ack on the expiry edge wins
        do_txn(1'b0, 1'b0, 32'h0000_0777, 32'h0, 32'h0BAD_CAFE, TO, 1'b0);
        // No ack: strobe for TO cycles, then error
        @(negedge clock);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h0000_0100;
        @(posedge clock);
        for (int j = 0; j < TO; j++) begin
            @(negedge clock);
            core_req = 1'b0;
            check("to_rd", 64'(mem_rd), 64'd1);
            check("to_err_early", 64'(core_err), 64'd0);
        end
        @(negedge clock);
        check("to_err", 64'(core_err), 64'd1);
        check("to_busy", 64'(core_busy), 64'd1);
        check_quiet("to");
        do_reset();
`else
        // Without the timeout option ISSUE waits indefinitely
        do_txn(1'b0, 1'b0, 32'h0000_0777, 32'h0, 32'h0BAD_CAFE, 20, 1'b0);
`endif

        // Reset one cycle into a read
        @(negedge clock);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h0000_4444;
        @(posedge clock);
        @(negedge clock);
        core_req = 1'b0;
        check("mid_rd_pre", 64'(mem_rd), 64'd1);
        @(negedge clock);
        check("mid_rd_pre2", 64'(mem_rd), 64'd1);
        reset   = 1'b1;
        mem_ack = 1'b1;
        #1;
        check("mid_rd_drop", 64'(mem_rd), 64'd0);
        check("mid_busy", 64'(core_busy), 64'd0);
        check("mid_ready", 64'(core_ready), 64'd0);
        @(negedge clock);
        check("mid_ready2", 64'(core_ready), 64'd0);
        reset   = 1'b0;
        mem_ack = 1'b0;
        exp_mbr = 32'd0;
        @(negedge clock);
        check("mid_ready3", 64'(core_ready), 64'd0);
        do_txn(1'b0, 1'b0, 32'h0000_4444, 32'h0, 32'h1357_9BDF, 2, 1'b0);

        // Address boundaries
        do_illegal(32'h0010_0000);
        do_reset();
        do_illegal(32'hFFFF_FFFF);
        do_reset();
        do_txn(1'b0, 1'b1, 32'h000F_FFFF, 32'h0, 32'h2468_ACE0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
